// File: rtl/des_pkg.sv
// des_pkg: DES key-schedule tables, shift schedule, FSM encoding and 28-bit rotate helpers
package des_pkg;

    typedef enum logic [1:0] {IDLE, EMIT, FIN} state_t;

    localparam int PC1 [1:56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [1:48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Shift schedule SH[1:16]: bit n-1 is set when round n rotates by two, clear when by one
    localparam logic [15:0] SH = 16'h7EFC;

    // Round number mod 16 (round 16 encoded as 0) selects its shift amount
    function automatic logic sh_two(input logic [3:0] n);
        return SH[n - 4'd1];
    endfunction

    function automatic logic [1:28] rotl28(input logic [1:28] x, input logic two);
        return two ? {x[3:28], x[1:2]} : {x[2:28], x[1]};
    endfunction

    function automatic logic [1:28] rotr28(input logic [1:28] x, input logic two);
        return two ? {x[27:28], x[1:26]} : {x[28], x[1:27]};
    endfunction

endpackage

// File: rtl/des_key_sched_seq_if.sv
// des_key_sched_seq_if: subkey stream from the key schedule to the round engine
interface des_key_sched_seq_if;
    logic [1:48] subkey;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [4:0]  key_round;

    modport master (output subkey, subkey_valid, key_round, input subkey_ready);
    modport slave  (input subkey, subkey_valid, key_round, output subkey_ready);
endinterface

// File: rtl/des_pc2.sv
// des_pc2: combinational PC2 permutation of the 56-bit C/D pair into a 48-bit round subkey
module des_pc2
    import des_pkg::*;
(
    input  logic [1:56] cd,
    output logic [1:48] k
);
    logic unused_cd;

    for (genvar i = 1; i <= 48; i++) begin : g_pc2
        assign k[i] = cd[PC2[i]];
    end

    assign unused_cd = ^{cd[9], cd[18], cd[22], cd[25], cd[35], cd[38], cd[43], cd[54]};
endmodule

// File: rtl/des_key_sched_seq.sv
// des_key_sched_seq: emits the 16 DES round subkeys one per handshake, forward or reversed
module des_key_sched_seq
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        decrypt,
    input  logic [1:64] key,
    output logic        busy,
    output logic        done,
    des_key_sched_seq_if.master sk
);
    state_t      state_q, state_d;
    logic [1:28] c_q, c_d, d_q, d_d;
    logic [4:0]  step_q, step_d;
    logic        dec_q, dec_d;
    logic [1:56] pc1_k;
    logic [1:48] subkey;
    logic [4:0]  round;
    logic [3:0]  sh_idx;
    logic        valid, two, unused_parity;

    for (genvar i = 1; i <= 56; i++) begin : g_pc1
        assign pc1_k[i] = key[PC1[i]];
    end

    assign unused_parity = ^{key[8], key[16], key[24], key[32], key[40], key[48], key[56], key[64]};

    des_pc2 u_pc2 (.cd({c_q, d_q}), .k(subkey));

    // EMIT step 0 is the load cycle, so the first subkey lands one full cycle after the start edge
    assign valid           = state_q == EMIT && step_q != 5'd0;
    assign round           = valid ? (dec_q ? 5'd17 - step_q : step_q) : 5'd0;
    assign sh_idx          = dec_q ? round[3:0] : round[3:0] + 4'd1;
    assign two             = sh_two(sh_idx);
    assign sk.subkey       = subkey;
    assign sk.subkey_valid = valid;
    assign sk.key_round    = round;
    assign busy            = state_q == EMIT;
    assign done            = state_q == FIN;

    // Next state: load halves on start, rotate toward the next round on each accepted subkey
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        step_d  = step_q;
        dec_d   = dec_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = EMIT;
                step_d  = 5'd0;
                dec_d   = decrypt;
                c_d     = decrypt ? pc1_k[1:28] : rotl28(pc1_k[1:28], 1'b0);
                d_d     = decrypt ? pc1_k[29:56] : rotl28(pc1_k[29:56], 1'b0);
            end
            EMIT: if (step_q == 5'd0) begin
                step_d = 5'd1;
            end else if (sk.subkey_ready) begin
                if (step_q == 5'd16) begin
                    state_d = FIN;
                    step_d  = 5'd0;
                end else begin
                    step_d = step_q + 5'd1;
                    c_d    = dec_q ? rotr28(c_q, two) : rotl28(c_q, two);
                    d_d    = dec_q ? rotr28(d_q, two) : rotl28(d_q, two);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and key-half registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            step_q  <= '0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            step_q  <= step_d;
            dec_q   <= dec_d;
        end
    end
endmodule
